// File: rtl/uart_rx_if.sv
// Serial-line and RX-FIFO-side signals of the UART receiver.
// The receiver is the master (it drives the FIFO write side); the environment is the slave.
interface uart_rx_if;
   logic        rx;
   logic [15:0] baud_divisor;
   logic [1:0]  i_parity_type;
   logic        i_fifo_full;
   logic [7:0]  rx_data;
   logic        o_fifo_wr_en;
   logic        o_parity_err;
   logic        o_frame_err;
   logic        o_overrun;
   logic        o_busy;

   modport master (
      input  rx, baud_divisor, i_parity_type, i_fifo_full,
      output rx_data, o_fifo_wr_en, o_parity_err, o_frame_err, o_overrun, o_busy
   );

   modport slave (
      output rx, baud_divisor, i_parity_type, i_fifo_full,
      input  rx_data, o_fifo_wr_en, o_parity_err, o_frame_err, o_overrun, o_busy
   );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx, samples each bit mid-period with a runtime baud
// divisor, checks parity/stop, and pushes completed bytes into the RX FIFO.
module uart_rx #(
   parameter int unsigned CLK_FREQ = 50000000
) (
   input logic     clk,
   input logic     rst_n,
   uart_rx_if.master bus
);

   if (CLK_FREQ == 0) begin : gBadClkFreq
      $error("uart_rx: CLK_FREQ must be nonzero");
   end

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK_WAIT
   } state_e;

   state_e      state_q, state_d;
   logic        rxMeta_q, rxSync_q;
   logic [15:0] clkCnt_q, clkCnt_d;
   logic [2:0]  bitCnt_q, bitCnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        parErr_q, parErr_d;
   logic [7:0]  rxData_q, rxData_d;
   logic        wrEn_q, wrEn_d;
   logic        parityPulse_q, parityPulse_d;
   logic        framePulse_q, framePulse_d;
   logic        overrun_q, overrun_d;

   logic [15:0] halfCnt, fullCnt;
   logic        tick;
   logic        expParity;

   // START uses the half-bit count so every later sample lands mid-bit.
   assign halfCnt = (bus.baud_divisor >> 1) - 16'd1;
   assign fullCnt = bus.baud_divisor - 16'd1;
   assign tick    = (clkCnt_q == ((state_q == START) ? halfCnt : fullCnt));

   always_comb begin
      case (bus.i_parity_type)
         2'b01:   expParity = ^shift_q;
         2'b11:   expParity = ~^shift_q;
         2'b10:   expParity = 1'b1;
         default: expParity = rxSync_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rxMeta_q      <= 1'b1;
         rxSync_q      <= 1'b1;
         state_q       <= IDLE;
         clkCnt_q      <= '0;
         bitCnt_q      <= '0;
         shift_q       <= '0;
         parErr_q      <= 1'b0;
         rxData_q      <= '0;
         wrEn_q        <= 1'b0;
         parityPulse_q <= 1'b0;
         framePulse_q  <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         rxMeta_q      <= bus.rx;
         rxSync_q      <= rxMeta_q;
         state_q       <= state_d;
         clkCnt_q      <= clkCnt_d;
         bitCnt_q      <= bitCnt_d;
         shift_q       <= shift_d;
         parErr_q      <= parErr_d;
         rxData_q      <= rxData_d;
         wrEn_q        <= wrEn_d;
         parityPulse_q <= parityPulse_d;
         framePulse_q  <= framePulse_d;
         overrun_q     <= overrun_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      bitCnt_d      = bitCnt_q;
      shift_d       = shift_q;
      parErr_d      = parErr_q;
      rxData_d      = rxData_q;
      wrEn_d        = 1'b0;
      parityPulse_d = 1'b0;
      framePulse_d  = 1'b0;
      overrun_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (!rxSync_q) state_d = START;
         end
         START: begin
            if (tick) begin
               if (rxSync_q) begin
                  state_d = IDLE;
               end else begin
                  state_d  = DATA;
                  bitCnt_d = 3'd0;
                  parErr_d = 1'b0;
               end
            end
         end
         DATA: begin
            if (tick) begin
               shift_d  = {rxSync_q, shift_q[7:1]};
               bitCnt_d = bitCnt_q + 3'd1;
               if (bitCnt_q == 3'd7) begin
                  state_d = (bus.i_parity_type != 2'b00) ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            if (tick) begin
               parErr_d = (rxSync_q != expParity);
               state_d  = STOP;
            end
         end
         STOP: begin
            if (tick) begin
               if (rxSync_q) begin
                  state_d       = IDLE;
                  parityPulse_d = parErr_q;
                  if (bus.i_fifo_full) begin
                     overrun_d = 1'b1;
                  end else begin
                     wrEn_d   = 1'b1;
                     rxData_d = shift_q;
                  end
               end else begin
                  framePulse_d = 1'b1;
                  state_d      = BREAK_WAIT;
               end
            end
         end
         BREAK_WAIT: begin
            if (rxSync_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Restart the bit timer on every state entry and after each sample point.
      clkCnt_d = ((state_d != state_q) || tick) ? 16'd0 : clkCnt_q + 16'd1;
   end

   assign bus.rx_data      = rxData_q;
   assign bus.o_fifo_wr_en = wrEn_q;
   assign bus.o_parity_err = parityPulse_q;
   assign bus.o_frame_err  = framePulse_q;
   assign bus.o_overrun    = overrun_q;
   assign bus.o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a serial-line model drives frames, expected
// completion events go into a scoreboard queue and are compared as the DUT pulses.
module tb_uart_rx;
   logic clk = 1'b0;
   logic rst_n;
   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;
   int   fallCyc    = 0;
   logic [7:0]  lastData = 8'h00;
   logic [11:0] expQ[$];
   logic [11:0] obsQ[$];
   int          obsCycQ[$];

   uart_rx_if bus();

   uart_rx #(.CLK_FREQ(50000000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Every cycle with any pulse becomes one observed event {wr, perr, ferr, ovr, data}.
   always @(negedge clk) begin
      if (bus.o_fifo_wr_en || bus.o_parity_err || bus.o_frame_err || bus.o_overrun) begin
         obsQ.push_back({bus.o_fifo_wr_en, bus.o_parity_err, bus.o_frame_err, bus.o_overrun, bus.rx_data});
         obsCycQ.push_back(cyc);
      end
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic parityOf(input logic [1:0] mode, input logic [7:0] d);
      case (mode)
         2'b01:   return ^d;
         2'b11:   return ~^d;
         default: return 1'b1;
      endcase
   endfunction

   task automatic pushExpected(input logic wr, input logic perr, input logic ferr, input logic ovr, input logic [7:0] d);
      if (wr) lastData = d;
      expQ.push_back({wr, perr, ferr, ovr, lastData});
   endtask

   // Serial line model; leaves rx low afterwards when the stop bit is 0 (break).
   task automatic applyStimulus(input logic [7:0] data, input bit withPar, input logic parBit,
                                input logic stopBit, input int d);
      fallCyc = cyc;
      bus.rx = 1'b0;
      repeat (d) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.rx = data[i];
         repeat (d) @(negedge clk);
      end
      if (withPar) begin
         bus.rx = parBit;
         repeat (d) @(negedge clk);
      end
      bus.rx = stopBit;
      repeat (d) @(negedge clk);
      if (stopBit) bus.rx = 1'b1;
   endtask

   task automatic waitEvents();
      int n = 0;
      while (obsQ.size() < expQ.size() && n < 300) begin
         @(negedge clk);
         n++;
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.rx = 1'b1;
      bus.baud_divisor = 16'd16;
      bus.i_parity_type = 2'b00;
      bus.i_fifo_full = 1'b0;
      repeat (3) @(negedge clk);
      compared++;
      if (bus.rx_data !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL reset_data: got %h want 00", bus.rx_data);
      end
      compared++;
      if ({bus.o_fifo_wr_en, bus.o_parity_err, bus.o_frame_err, bus.o_overrun, bus.o_busy} !== 5'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_flags: got %b want 00000",
                  {bus.o_fifo_wr_en, bus.o_parity_err, bus.o_frame_err, bus.o_overrun, bus.o_busy});
      end
      rst_n = 1'b1;
      lastData = 8'h00;
      repeat (8) @(negedge clk);
      compared++;
      if (bus.o_busy !== 1'b0 || obsQ.size() !== 0) begin
         mismatched++;
         $display("[TB] FAIL reset_idle: got busy=%b events=%0d want busy=0 events=0", bus.o_busy, obsQ.size());
      end
   endtask

   task automatic test_basic();
      logic [11:0] e, o;
      int c;
      bus.baud_divisor = 16'd16;
      bus.i_parity_type = 2'b00;
      pushExpected(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
      applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1, 16);
      waitEvents();
      compared++;
      if (obsQ.size() !== expQ.size()) begin
         mismatched++;
         $display("[TB] FAIL basic_count: got %0d events want %0d", obsQ.size(), expQ.size());
      end
      while (obsQ.size() > 0 && expQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); c = obsCycQ.pop_front();
         compared++;
         if (o !== e) begin
            mismatched++;
            $display("[TB] FAIL basic_event: got %03h want %03h", o, e);
         end
         compared++;
         if (c - fallCyc < 154 || c - fallCyc > 156) begin
            mismatched++;
            $display("[TB] FAIL basic_latency: got %0d want 155+-1", c - fallCyc);
         end
      end
      obsQ.delete(); obsCycQ.delete(); expQ.delete();
   endtask

   task automatic test_parity();
      logic [11:0] e, o;
      bus.baud_divisor = 16'd16;
      bus.i_parity_type = 2'b01;
      pushExpected(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
      applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1, 16);
      repeat (5) @(negedge clk);
      pushExpected(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
      applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1, 16);
      repeat (5) @(negedge clk);
      bus.i_parity_type = 2'b10;
      pushExpected(1'b1, 1'b1, 1'b0, 1'b0, 8'hC1);
      applyStimulus(8'hC1, 1'b1, 1'b0, 1'b1, 16);
      waitEvents();
      compared++;
      if (obsQ.size() !== expQ.size()) begin
         mismatched++;
         $display("[TB] FAIL parity_count: got %0d events want %0d", obsQ.size(), expQ.size());
      end
      while (obsQ.size() > 0 && expQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); void'(obsCycQ.pop_front());
         compared++;
         if (o !== e) begin
            mismatched++;
            $display("[TB] FAIL parity_event: got %03h want %03h", o, e);
         end
      end
      obsQ.delete(); obsCycQ.delete(); expQ.delete();
      bus.i_parity_type = 2'b00;
   endtask

   task automatic test_frame_error();
      logic [11:0] e, o;
      bus.baud_divisor = 16'd16;
      bus.i_parity_type = 2'b00;
      pushExpected(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 16);
      repeat (64) @(negedge clk);
      compared++;
      if (bus.o_busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL break_busy: got %b want 1", bus.o_busy);
      end
      bus.rx = 1'b1;
      repeat (6) @(negedge clk);
      compared++;
      if (bus.o_busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL break_release: got busy=%b want 0", bus.o_busy);
      end
      waitEvents();
      compared++;
      if (obsQ.size() !== expQ.size()) begin
         mismatched++;
         $display("[TB] FAIL frame_count: got %0d events want %0d", obsQ.size(), expQ.size());
      end
      while (obsQ.size() > 0 && expQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); void'(obsCycQ.pop_front());
         compared++;
         if (o !== e) begin
            mismatched++;
            $display("[TB] FAIL frame_event: got %03h want %03h", o, e);
         end
      end
      obsQ.delete(); obsCycQ.delete(); expQ.delete();
   endtask

   task automatic test_glitch();
      bus.baud_divisor = 16'd16;
      bus.rx = 1'b0;
      repeat (4) @(negedge clk);
      bus.rx = 1'b1;
      compared++;
      if (bus.o_busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL glitch_start: got busy=%b want 1", bus.o_busy);
      end
      repeat (10) @(negedge clk);
      compared++;
      if (bus.o_busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL glitch_idle: got busy=%b want 0", bus.o_busy);
      end
      repeat (40) @(negedge clk);
      compared++;
      if (obsQ.size() !== 0) begin
         mismatched++;
         $display("[TB] FAIL glitch_quiet: got %0d events want 0", obsQ.size());
      end
      obsQ.delete(); obsCycQ.delete();
   endtask

   task automatic test_overrun();
      logic [11:0] e, o;
      bus.baud_divisor = 16'd16;
      bus.i_parity_type = 2'b00;
      bus.i_fifo_full = 1'b1;
      pushExpected(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      applyStimulus(8'h81, 1'b0, 1'b0, 1'b1, 16);
      repeat (4) @(negedge clk);
      bus.i_fifo_full = 1'b0;
      pushExpected(1'b1, 1'b0, 1'b0, 1'b0, 8'h7E);
      applyStimulus(8'h7E, 1'b0, 1'b0, 1'b1, 16);
      waitEvents();
      compared++;
      if (obsQ.size() !== expQ.size()) begin
         mismatched++;
         $display("[TB] FAIL overrun_count: got %0d events want %0d", obsQ.size(), expQ.size());
      end
      while (obsQ.size() > 0 && expQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); void'(obsCycQ.pop_front());
         compared++;
         if (o !== e) begin
            mismatched++;
            $display("[TB] FAIL overrun_event: got %03h want %03h", o, e);
         end
      end
      obsQ.delete(); obsCycQ.delete(); expQ.delete();
   endtask

   task automatic test_back_to_back();
      logic [11:0] e, o;
      logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h5A};
      bus.baud_divisor = 16'd8;
      bus.i_parity_type = 2'b11;
      for (int i = 0; i < 3; i++) begin
         pushExpected(1'b1, 1'b0, 1'b0, 1'b0, bytes[i]);
         applyStimulus(bytes[i], 1'b1, parityOf(2'b11, bytes[i]), 1'b1, 8);
      end
      waitEvents();
      compared++;
      if (obsQ.size() !== expQ.size()) begin
         mismatched++;
         $display("[TB] FAIL b2b_count: got %0d events want %0d", obsQ.size(), expQ.size());
      end
      while (obsQ.size() > 0 && expQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); void'(obsCycQ.pop_front());
         compared++;
         if (o !== e) begin
            mismatched++;
            $display("[TB] FAIL b2b_event: got %03h want %03h", o, e);
         end
      end
      obsQ.delete(); obsCycQ.delete(); expQ.delete();
   endtask

   task automatic test_reset_mid_frame();
      logic [11:0] e, o;
      bus.baud_divisor = 16'd8;
      bus.i_parity_type = 2'b11;
      pushExpected(1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
      applyStimulus(8'h11, 1'b1, parityOf(2'b11, 8'h11), 1'b1, 8);
      bus.rx = 1'b0;
      repeat (8) @(negedge clk);
      bus.rx = 1'b1;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      compared++;
      if (bus.rx_data !== 8'h00 || bus.o_busy !== 1'b0 || bus.o_fifo_wr_en !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL midreset_outputs: got data=%h busy=%b wr=%b want 00/0/0",
                  bus.rx_data, bus.o_busy, bus.o_fifo_wr_en);
      end
      rst_n = 1'b1;
      lastData = 8'h00;
      bus.rx = 1'b1;
      repeat (30) @(negedge clk);
      pushExpected(1'b1, 1'b0, 1'b0, 1'b0, 8'hC3);
      applyStimulus(8'hC3, 1'b1, parityOf(2'b11, 8'hC3), 1'b1, 8);
      waitEvents();
      compared++;
      if (obsQ.size() !== expQ.size()) begin
         mismatched++;
         $display("[TB] FAIL midreset_count: got %0d events want %0d", obsQ.size(), expQ.size());
      end
      while (obsQ.size() > 0 && expQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); void'(obsCycQ.pop_front());
         compared++;
         if (o !== e) begin
            mismatched++;
            $display("[TB] FAIL midreset_event: got %03h want %03h", o, e);
         end
      end
      obsQ.delete(); obsCycQ.delete(); expQ.delete();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_frame_error();
      test_glitch();
      test_overrun();
      test_back_to_back();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
